// File: rtl/irq_pkg.sv
// Shared constants and FSM state encoding for the interrupt controller.
package irq_pkg;

  localparam int unsigned N   = 8;
  localparam int unsigned IDW = 3;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  function automatic logic [N-1:0] id_onehot(input logic [IDW-1:0] id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pri_encoder.sv
// 8->3 priority encoder with valid; the highest set index wins.
module pri_encoder (
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid
);

  always_comb begin
    out = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (in[i]) out = i[2:0];
    end
    valid = |in;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detects raw lines into a pending register, arbitrates the
// unmasked set through pri_encoder and runs a req/ack/eoi handshake with the consumer.
module irq_ctrl
  import irq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   mask,
  input  logic           irq_ack,
  input  logic           irq_eoi,
  output logic           irq_req,
  output logic [IDW-1:0] irq_id,
  output logic           busy,
  output logic [N-1:0]   pending
);

  logic [N-1:0]   irq_prev_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   rise, ack_clr, enc_in;
  logic [1:0]     state_q, state_d;
  logic           req_q, req_d;
  logic           busy_q, busy_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] enc_out;
  logic           enc_valid;
  logic           ack_accept;

  assign rise       = irq_in & ~irq_prev_q;
  assign ack_accept = (state_q == REQ) && irq_ack;
  assign ack_clr    = ack_accept ? id_onehot(id_q) : '0;
  // A fresh edge on the line being acked wins over the clear so the event is kept.
  assign pending_d  = rise | (pending_q & ~ack_clr);
  assign enc_in     = pending_q & ~mask;

  pri_encoder u_pri_encoder (
    .in    (enc_in),
    .out   (enc_out),
    .valid (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    busy_d  = busy_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          id_d    = enc_out;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack outranks withdrawal; the id stays frozen until we get back to IDLE.
        if (irq_ack) begin
          req_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SERVICE;
        end else if (mask[id_q]) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      state_q    <= IDLE;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      id_q       <= '0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      state_q    <= state_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      id_q       <= id_d;
    end
  end

  assign irq_req = req_q;
  assign irq_id  = id_q;
  assign busy    = busy_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq_req;
  logic [2:0] irq_id;
  logic       busy;
  logic [7:0] pending;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  irq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .mask    (mask),
    .irq_ack (irq_ack),
    .irq_eoi (irq_eoi),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .busy    (busy),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: 0 = waiting, 1 = requesting, 2 = servicing.
  int       m_phase = 0;
  bit [7:0] m_pend  = '0;
  bit [7:0] m_last  = '0;
  bit       m_req   = 0;
  bit       m_busy  = 0;
  int       m_id    = 0;
  bit [7:0] m_new, m_vis;

  function automatic int highest(input bit [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_pend = '0; m_last = '0; m_req = 0; m_busy = 0; m_id = 0;
    end else begin
      m_new = irq_in & ~m_last;
      m_vis = m_pend & ~mask;
      if (m_phase == 0) begin
        if (m_vis != 0) begin
          m_id = highest(m_vis); m_req = 1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (irq_ack) begin
          m_pend[m_id] = 1'b0; m_req = 0; m_busy = 1; m_phase = 2;
        end else if (mask[m_id]) begin
          m_req = 0; m_phase = 0;
        end
      end else begin
        if (irq_eoi) begin
          m_busy = 0; m_phase = 0;
        end
      end
      m_pend = m_pend | m_new;
      m_last = irq_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model irq_req", 32'(irq_req), 32'(m_req));
      check("model busy", 32'(busy), 32'(m_busy));
      check("model pending", 32'(pending), 32'(m_pend));
      if (m_req) check("model irq_id", 32'(irq_id), 32'(m_id[2:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE with pending work: expect request for id, ack it, then eoi.
  task automatic serve(input int id, input logic [7:0] pend_after_ack);
    tick();
    check("serve req", 32'(irq_req), 32'd1);
    check("serve id", 32'(irq_id), 32'(id));
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("serve busy", 32'(busy), 32'd1);
    check("serve pending", 32'(pending), 32'(pend_after_ack));
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    check("serve eoi busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mask = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pending", 32'(pending), 32'h0);
    check("reset req", 32'(irq_req), 32'd0);
    check("reset id", 32'(irq_id), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cmp_en = 1;

    // Single event on line 2.
    irq_in = 8'h04;
    tick();
    check("t1 pending", 32'(pending), 32'h04);
    check("t1 req early", 32'(irq_req), 32'd0);
    irq_in = 8'h00;
    serve(2, 8'h00);

    // Three simultaneous rises served highest first.
    irq_in = 8'h91;
    tick();
    check("t2 pending", 32'(pending), 32'h91);
    irq_in = 8'h00;
    serve(7, 8'h11);
    serve(4, 8'h01);
    serve(0, 8'h00);

    // Masking and withdrawal.
    mask = 8'h80; irq_in = 8'h82;
    tick();
    irq_in = 8'h00;
    serve(1, 8'h80);
    mask = 8'h00;
    serve(7, 8'h00);
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    tick();
    check("t3 req id3", 32'(irq_id), 32'd3);
    mask = 8'h08;
    tick();
    check("t3 withdraw req", 32'(irq_req), 32'd0);
    check("t3 withdraw pend", 32'(pending), 32'h08);
    tick();
    check("t3 masked idle", 32'(irq_req), 32'd0);
    mask = 8'h00;
    serve(3, 8'h00);

    // Re-rise of line 5 in the ack cycle.
    irq_in = 8'h20;
    tick();
    irq_in = 8'h00;
    tick();
    check("t4 id5", 32'(irq_id), 32'd5);
    irq_in = 8'h20; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t4 pend kept", 32'(pending), 32'h20);
    check("t4 busy", 32'(busy), 32'd1);
    irq_in = 8'h00; irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    serve(5, 8'h00);

    // Spurious handshakes.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t6 ack idle req", 32'(irq_req), 32'd0);
    check("t6 ack idle busy", 32'(busy), 32'd0);
    irq_in = 8'h40;
    tick();
    irq_in = 8'h00;
    tick();
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    check("t6 eoi req", 32'(irq_req), 32'd1);
    check("t6 eoi id", 32'(irq_id), 32'd6);
    check("t6 eoi pend", 32'(pending), 32'h40);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;

    // Async reset while servicing with pending 0A.
    irq_in = 8'h0A;
    tick();
    irq_in = 8'h00;
    tick();
    check("t5 id3", 32'(irq_id), 32'd3);
    irq_in = 8'h08; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t5 pend", 32'(pending), 32'h0A);
    check("t5 busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async pend", 32'(pending), 32'h0);
    check("t5 async busy", 32'(busy), 32'd0);
    check("t5 async req", 32'(irq_req), 32'd0);
    check("t5 async id", 32'(irq_id), 32'd0);
    irq_in = 8'h02;
    tick();
    rst_n = 1'b1;
    tick();
    check("t5 post pend", 32'(pending), 32'h02);
    irq_in = 8'h00;
    serve(1, 8'h00);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      irq_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq_in & 8'($urandom);
      mask    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      irq_ack = ($urandom_range(0, 2) == 0);
      irq_eoi = ($urandom_range(0, 2) == 0);
      tick();
    end
    irq_ack = 1'b0; irq_eoi = 1'b0;
    tick();
    @(negedge clk);
    cmp_en = 0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller stage wrapped around the 8-input priority encoder.
- Edge-detects raw interrupt lines and latches them into a pending register, then applies a mask and feeds the result to the encoder.
- Uses the encoder's out/valid to run a request/acknowledge/end-of-interrupt handshake with a CPU-side consumer.
- Pending bits are cleared on acknowledge; highest index wins, matching the encoder's priority order.

Parameters:
- N, 8: number of interrupt lines. Fixed at 8 to match the encoder width; other values are unsupported.
- IDW, 3: interrupt ID width, equal to clog2(N).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  8  raw interrupt lines, synchronous to clk, level; a 0->1 transition is an event.
- mask  input  8  1 = line masked (pending still latches, but is not presented to the encoder).
- irq_ack  input  1  consumer accepts the current request; 1-cycle pulse.
- irq_eoi  input  1  consumer finished servicing; 1-cycle pulse.
- irq_req  output  1  request to consumer; held until ack or withdrawal.
- irq_id  output  3  ID of the requested interrupt; stable while irq_req=1.
- busy  output  1  high while in SERVICE.
- pending  output  8  current pending register, for status reads.

Behaviour:
- Reset (async assert, sync release): pending=0, irq_prev=0, state=IDLE, irq_req=0, irq_id=0, busy=0.
  - irq_prev resets to 0, so a line already high at release counts as an edge on the first clock.
- Edge detect: rise[i] = irq_in[i] & ~irq_prev[i]. irq_prev <= irq_in every cycle.
- Pending update, per bit, each edge:
  - Set if rise[i].
  - Else clear if an accepted ack targets i.
  - Else hold.
  - Set beats clear in the same cycle, so a new event on the line being acked is not lost.
- Encoder input: pending & ~mask, combinational into the pri_encoder instance, giving enc_out and enc_valid.
- FSM states, encoded in the package:
  - IDLE: irq_req=0, busy=0. If enc_valid: irq_id <= enc_out, irq_req <= 1, go to REQ.
  - REQ: irq_req=1, irq_id frozen.
    - irq_ack=1: clear pending[irq_id], irq_req <= 0, busy <= 1, go to SERVICE.
    - Else if mask[irq_id]=1: withdraw. irq_req <= 0, go to IDLE; the pending bit is kept.
    - Ack has priority over withdrawal in the same cycle.
    - A higher-priority arrival while in REQ does NOT change irq_id; there is no re-arbitration until IDLE.
  - SERVICE: busy=1, irq_req=0. On irq_eoi: busy <= 0, go to IDLE. New events keep latching into pending. No nesting or preemption.
- Ignored inputs: irq_ack outside REQ; irq_eoi outside SERVICE.
- Latency:
  - irq_in rises before edge k: pending set at k, irq_req=1 after edge k+1 (2 cycles from line to request).
  - Back-to-back: eoi sampled at edge e puts the FSM in IDLE; the next request asserts after edge e+1.
- Simultaneous rises: all latch; the highest unmasked index is served first, the others remain pending.
- All outputs are registered; the only combinational path is the mask into the encoder into FSM next-state logic.

Decomposition:
- Package irq_pkg:
  - State encoding IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - Constants N=8, IDW=3.
- Sub-module: the existing pri_encoder (8->3 with valid), instantiated once. No other sub-modules.

Test Plan:
- Reset, then pulse irq_in=8'b0000_0100 with mask=0:
  - pending=8'h04 after 1 edge; irq_req=1, irq_id=3'd2 after 2 edges.
  - ack clears pending to 0; busy=1; eoi returns to IDLE with busy=0.
- irq_in rises 8'b1001_0001 in one cycle:
  - Served in order irq_id=7, then 4, then 0, each via ack/eoi.
  - pending goes 8'h91 -> 8'h11 -> 8'h01 -> 8'h00.
- Masking:
  - mask=8'h80, event on bits 7 and 1: irq_id=1 is served.
  - Clearing mask afterwards yields irq_id=7.
  - Setting mask[id] while in REQ with no ack: irq_req drops next cycle, pending bit retained, state returns to IDLE.
- New event in the ack cycle:
  - While in REQ for id 5, irq_in[5] re-rises in the same cycle as irq_ack=1.
  - pending[5] stays 1 and is re-requested after eoi.
- Async reset mid-operation:
  - Assert rst_n=0 in SERVICE with pending=8'h0A.
  - All outputs go to 0 immediately, without a clock edge.
  - After release with irq_in held at 8'h02, pending=8'h02 after the first edge.
- Spurious handshakes:
  - irq_ack in IDLE and irq_eoi in REQ: no state change, pending unchanged.
